// File: rtl/rf_writeback_ctrl.sv
// Writeback merge of ALU/LSU/MDU onto register file ports W1/W2, with scoreboard.
// Optional macro RF_WB_FWD_EN adds forwarding of in-flight writes to the issue checks.
module rf_writeback_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alu_we_i,
    input  logic [ADDR_WIDTH-1:0]     alu_waddr_i,
    input  logic [DATA_WIDTH-1:0]     alu_wdata_i,
    input  logic                      lsu_we_i,
    input  logic [ADDR_WIDTH-1:0]     lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0]     lsu_wdata_i,
    input  logic                      mdu_valid_i,
    input  logic [ADDR_WIDTH-1:0]     mdu_waddr_i,
    input  logic [DATA_WIDTH-1:0]     mdu_wdata_i,
    output logic                      mdu_ready_o,
    input  logic                      pend_set_i,
    input  logic [ADDR_WIDTH-1:0]     pend_rd_i,
    input  logic [ADDR_WIDTH-1:0]     chk_a_i,
    input  logic [ADDR_WIDTH-1:0]     chk_b_i,
    input  logic [ADDR_WIDTH-1:0]     chk_c_i,
    output logic                      hazard_o,
    output logic                      we_a_o,
    output logic [ADDR_WIDTH-1:0]     waddr_a_o,
    output logic [DATA_WIDTH-1:0]     wdata_a_o,
    output logic                      we_b_o,
    output logic [ADDR_WIDTH-1:0]     waddr_b_o,
    output logic [DATA_WIDTH-1:0]     wdata_b_o,
`ifdef RF_WB_FWD_EN
    output logic                      fwd_sel_a_o,
    output logic                      fwd_sel_b_o,
    output logic                      fwd_sel_c_o,
    output logic [DATA_WIDTH-1:0]     fwd_data_a_o,
    output logic [DATA_WIDTH-1:0]     fwd_data_b_o,
    output logic [DATA_WIDTH-1:0]     fwd_data_c_o,
`endif
    output logic [(1<<ADDR_WIDTH)-1:0] pend_o
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic                  we_a_q, we_a_d, we_b_q, we_b_d;
    logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_a_d, waddr_b_q, waddr_b_d;
    logic [DATA_WIDTH-1:0] wdata_a_q, wdata_a_d, wdata_b_q, wdata_b_d;
    logic [NREG-1:0]       pend_q, pend_d;

    logic                  mdu_on_a, mdu_on_b, a_req, b_req;
    logic [ADDR_WIDTH-1:0] a_addr, b_addr;
    logic [DATA_WIDTH-1:0] a_data, b_data;
    logic [ADDR_WIDTH-1:0] chk [3];

    assign chk[0] = chk_a_i;
    assign chk[1] = chk_b_i;
    assign chk[2] = chk_c_i;

    // MDU fills whichever port its fixed-owner source leaves idle, A first.
    always_comb begin
        mdu_on_a    = mdu_valid_i && !alu_we_i;
        mdu_on_b    = mdu_valid_i && alu_we_i && !lsu_we_i;
        mdu_ready_o = mdu_on_a || mdu_on_b;
        a_req       = alu_we_i || mdu_on_a;
        a_addr      = alu_we_i ? alu_waddr_i : mdu_waddr_i;
        a_data      = alu_we_i ? alu_wdata_i : mdu_wdata_i;
        b_req       = lsu_we_i || mdu_on_b;
        b_addr      = lsu_we_i ? lsu_waddr_i : mdu_waddr_i;
        b_data      = lsu_we_i ? lsu_wdata_i : mdu_wdata_i;
        we_a_d      = a_req && (a_addr != '0);
        we_b_d      = b_req && (b_addr != '0)
                      && !(we_a_d && (a_addr == b_addr));
        waddr_a_d   = we_a_d ? a_addr : '0;
        wdata_a_d   = we_a_d ? a_data : '0;
        waddr_b_d   = we_b_d ? b_addr : '0;
        wdata_b_d   = we_b_d ? b_data : '0;
    end

    // Clears come from accepted long-op results even when their write is dropped.
    always_comb begin
        pend_d = pend_q;
        if (lsu_we_i)    pend_d[lsu_waddr_i] = 1'b0;
        if (mdu_ready_o) pend_d[mdu_waddr_i] = 1'b0;
        if (pend_set_i)  pend_d[pend_rd_i]   = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_a_q    <= 1'b0;
            waddr_a_q <= '0;
            wdata_a_q <= '0;
            we_b_q    <= 1'b0;
            waddr_b_q <= '0;
            wdata_b_q <= '0;
            pend_q    <= '0;
        end else begin
            we_a_q    <= we_a_d;
            waddr_a_q <= waddr_a_d;
            wdata_a_q <= wdata_a_d;
            we_b_q    <= we_b_d;
            waddr_b_q <= waddr_b_d;
            wdata_b_q <= wdata_b_d;
            pend_q    <= pend_d;
        end
    end

`ifdef RF_WB_FWD_EN
    logic                  fsel [3];
    logic [DATA_WIDTH-1:0] fdat [3];
`endif

    always_comb begin
        logic hit_a, hit_b, nz;
        hazard_o = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nz    = chk[i] != '0;
            hit_a = nz && we_a_q && (waddr_a_q == chk[i]);
            hit_b = nz && we_b_q && (waddr_b_q == chk[i]);
`ifdef RF_WB_FWD_EN
            fsel[i]  = hit_a || hit_b;
            fdat[i]  = hit_a ? wdata_a_q : (hit_b ? wdata_b_q : '0);
            hazard_o = hazard_o || (nz && pend_q[chk[i]]);
`else
            hazard_o = hazard_o || (nz && pend_q[chk[i]]) || hit_a || hit_b;
`endif
        end
    end

`ifdef RF_WB_FWD_EN
    assign fwd_sel_a_o  = fsel[0];
    assign fwd_sel_b_o  = fsel[1];
    assign fwd_sel_c_o  = fsel[2];
    assign fwd_data_a_o = fdat[0];
    assign fwd_data_b_o = fdat[1];
    assign fwd_data_c_o = fdat[2];
`endif

    assign we_a_o    = we_a_q;
    assign waddr_a_o = waddr_a_q;
    assign wdata_a_o = wdata_a_q;
    assign we_b_o    = we_b_q;
    assign waddr_b_o = waddr_b_q;
    assign wdata_b_o = wdata_b_q;
    assign pend_o    = pend_q;

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Self-checking bench for rf_writeback_ctrl: vector table with a
// scoreboard queue for registered writes, plus hand-written sequences.
module tb_rf_writeback_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_we_i, lsu_we_i, mdu_valid_i, pend_set_i;
    logic [4:0]  alu_waddr_i, lsu_waddr_i, mdu_waddr_i, pend_rd_i;
    logic [31:0] alu_wdata_i, lsu_wdata_i, mdu_wdata_i;
    logic [4:0]  chk_a_i, chk_b_i, chk_c_i;
    logic        mdu_ready_o, hazard_o, we_a_o, we_b_o;
    logic [4:0]  waddr_a_o, waddr_b_o;
    logic [31:0] wdata_a_o, wdata_b_o, pend_o;
`ifdef RF_WB_FWD_EN
    logic        fwd_sel_a_o, fwd_sel_b_o, fwd_sel_c_o;
    logic [31:0] fwd_data_a_o, fwd_data_b_o, fwd_data_c_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rf_writeback_ctrl #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_we_i(alu_we_i), .alu_waddr_i(alu_waddr_i), .alu_wdata_i(alu_wdata_i),
        .lsu_we_i(lsu_we_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
        .mdu_valid_i(mdu_valid_i), .mdu_waddr_i(mdu_waddr_i),
        .mdu_wdata_i(mdu_wdata_i), .mdu_ready_o(mdu_ready_o),
        .pend_set_i(pend_set_i), .pend_rd_i(pend_rd_i),
        .chk_a_i(chk_a_i), .chk_b_i(chk_b_i), .chk_c_i(chk_c_i),
        .hazard_o(hazard_o),
        .we_a_o(we_a_o), .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o),
        .we_b_o(we_b_o), .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o),
`ifdef RF_WB_FWD_EN
        .fwd_sel_a_o(fwd_sel_a_o), .fwd_sel_b_o(fwd_sel_b_o),
        .fwd_sel_c_o(fwd_sel_c_o), .fwd_data_a_o(fwd_data_a_o),
        .fwd_data_b_o(fwd_data_b_o), .fwd_data_c_o(fwd_data_c_o),
`endif
        .pend_o(pend_o)
    );

    typedef struct {
        string       name;
        logic        alu_we;  logic [4:0] alu_a; logic [31:0] alu_d;
        logic        lsu_we;  logic [4:0] lsu_a; logic [31:0] lsu_d;
        logic        mdu_v;   logic [4:0] mdu_a; logic [31:0] mdu_d;
        logic        x_ready;
        logic        x_we_a;  logic [4:0] x_wa_a; logic [31:0] x_wd_a;
        logic        x_we_b;  logic [4:0] x_wa_b; logic [31:0] x_wd_b;
    } vec_t;

    typedef struct {
        string       name;
        logic        we_a; logic [4:0] wa_a; logic [31:0] wd_a;
        logic        we_b; logic [4:0] wa_b; logic [31:0] wd_b;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        alu_we_i = 0; alu_waddr_i = 0; alu_wdata_i = 0;
        lsu_we_i = 0; lsu_waddr_i = 0; lsu_wdata_i = 0;
        mdu_valid_i = 0; mdu_waddr_i = 0; mdu_wdata_i = 0;
        pend_set_i = 0; pend_rd_i = 0;
        chk_a_i = 0; chk_b_i = 0; chk_c_i = 0;
    endtask

    function automatic vec_t mk(
        input string n,
        input logic aw, input logic [4:0] aa, input logic [31:0] ad,
        input logic lw, input logic [4:0] la, input logic [31:0] ld,
        input logic mv, input logic [4:0] ma, input logic [31:0] md,
        input logic rdy,
        input logic ewa, input logic [4:0] eaa, input logic [31:0] eda,
        input logic ewb, input logic [4:0] eab, input logic [31:0] edb);
        vec_t v;
        v.name = n;
        v.alu_we = aw; v.alu_a = aa; v.alu_d = ad;
        v.lsu_we = lw; v.lsu_a = la; v.lsu_d = ld;
        v.mdu_v = mv;  v.mdu_a = ma; v.mdu_d = md;
        v.x_ready = rdy;
        v.x_we_a = ewa; v.x_wa_a = eaa; v.x_wd_a = eda;
        v.x_we_b = ewb; v.x_wa_b = eab; v.x_wd_b = edb;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        exp_t e, g;
        @(negedge clk);
        idle();
        alu_we_i = v.alu_we; alu_waddr_i = v.alu_a; alu_wdata_i = v.alu_d;
        lsu_we_i = v.lsu_we; lsu_waddr_i = v.lsu_a; lsu_wdata_i = v.lsu_d;
        mdu_valid_i = v.mdu_v; mdu_waddr_i = v.mdu_a; mdu_wdata_i = v.mdu_d;
        #1 check({v.name, "_ready"}, {31'd0, mdu_ready_o}, {31'd0, v.x_ready});
        e.name = v.name;
        e.we_a = v.x_we_a; e.wa_a = v.x_wa_a; e.wd_a = v.x_wd_a;
        e.we_b = v.x_we_b; e.wa_b = v.x_wa_b; e.wd_b = v.x_wd_b;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check({g.name, "_we_a"}, {31'd0, we_a_o}, {31'd0, g.we_a});
        check({g.name, "_we_b"}, {31'd0, we_b_o}, {31'd0, g.we_b});
        if (g.we_a) begin
            check({g.name, "_wa_a"}, {27'd0, waddr_a_o}, {27'd0, g.wa_a});
            check({g.name, "_wd_a"}, wdata_a_o, g.wd_a);
        end
        if (g.we_b) begin
            check({g.name, "_wa_b"}, {27'd0, waddr_b_o}, {27'd0, g.wa_b});
            check({g.name, "_wd_b"}, wdata_b_o, g.wd_b);
        end
    endtask

    initial begin
        tbl[0] = mk("triple", 1,3,32'h11, 1,4,32'h22, 1,7,32'h77,
                    0, 1,3,32'h11, 1,4,32'h22);
        tbl[1] = mk("mdu_a",  0,0,0, 0,0,0, 1,7,32'h77,
                    1, 1,7,32'h77, 0,0,0);
        tbl[2] = mk("mdu_b",  1,5,32'h55, 0,0,0, 1,8,32'h88,
                    1, 1,5,32'h55, 1,8,32'h88);
        tbl[3] = mk("same_rd", 1,6,32'hAAAA, 1,6,32'hBBBB, 0,0,0,
                    0, 1,6,32'hAAAA, 0,0,0);
        tbl[4] = mk("x0_al",  1,0,32'h1, 1,0,32'h2, 0,0,0,
                    0, 0,0,0, 0,0,0);
        tbl[5] = mdu_x0();
        tbl[6] = mk("lsu_mdu", 0,0,0, 1,10,32'h1010, 1,11,32'h1111,
                    1, 1,11,32'h1111, 1,10,32'h1010);
        tbl[7] = mk("idle", 0,0,0, 0,0,0, 0,0,0, 0, 0,0,0, 0,0,0);
        tbl[8] = mk("mdu_lsu_same", 0,0,0, 1,4,32'h44, 1,4,32'h4D,
                    1, 1,4,32'h4D, 0,0,0);

        idle();
        rst_n = 0;
        #12;
        check("rst_we_a", {31'd0, we_a_o}, 0);
        check("rst_we_b", {31'd0, we_b_o}, 0);
        check("rst_pend", pend_o, 0);
        check("rst_hazard", {31'd0, hazard_o}, 0);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 9; i++) apply(tbl[i]);

        // scoreboard set / hazard / clear
        @(negedge clk); idle(); pend_set_i = 1; pend_rd_i = 9;
        #1 check("haz_none", {31'd0, hazard_o}, 0);
        @(posedge clk); #1 check("pend9_set", {31'd0, pend_o[9]}, 1);
        @(negedge clk); idle(); chk_a_i = 9;
        #1 check("haz_pend9", {31'd0, hazard_o}, 1);
        lsu_we_i = 1; lsu_waddr_i = 9; lsu_wdata_i = 32'h99;
        @(posedge clk); #1 check("pend9_clr", {31'd0, pend_o[9]}, 0);
        check("lsu9_we_b", {31'd0, we_b_o}, 1);
        @(negedge clk); idle(); chk_a_i = 9;
`ifdef RF_WB_FWD_EN
        #1 check("haz_fly9", {31'd0, hazard_o}, 0);
        check("fsel_a9", {31'd0, fwd_sel_a_o}, 1);
        check("fdat_a9", fwd_data_a_o, 32'h99);
`else
        #1 check("haz_fly9", {31'd0, hazard_o}, 1);
`endif
        @(negedge clk);
        #1 check("haz_gone9", {31'd0, hazard_o}, 0);

        // set beats clear, then MDU clears
        pend_set_i = 1; pend_rd_i = 9;
        lsu_we_i = 1; lsu_waddr_i = 9; lsu_wdata_i = 32'h5;
        @(posedge clk); #1 check("pend9_setwin", {31'd0, pend_o[9]}, 1);
        @(negedge clk); idle();
        mdu_valid_i = 1; mdu_waddr_i = 9; mdu_wdata_i = 32'h5;
        #1 check("mdu9_ready", {31'd0, mdu_ready_o}, 1);
        @(posedge clk); #1 check("pend9_mduclr", {31'd0, pend_o[9]}, 0);
        check("mdu9_wa_a", {27'd0, waddr_a_o}, 9);

        // same-rd conflict still clears the suppressed LSU's bit
        @(negedge clk); idle(); pend_set_i = 1; pend_rd_i = 6;
        @(posedge clk); #1 check("pend6_set", {31'd0, pend_o[6]}, 1);
        @(negedge clk); idle();
        alu_we_i = 1; alu_waddr_i = 6; alu_wdata_i = 32'hAAAA;
        lsu_we_i = 1; lsu_waddr_i = 6; lsu_wdata_i = 32'hBBBB;
        @(posedge clk); #1;
        check("conf_we_b", {31'd0, we_b_o}, 0);
        check("conf_wd_a", wdata_a_o, 32'hAAAA);
        check("conf_pend6", {31'd0, pend_o[6]}, 0);

        // x0 never becomes pending
        @(negedge clk); idle(); pend_set_i = 1; pend_rd_i = 20;
        @(negedge clk); idle(); pend_set_i = 1; pend_rd_i = 0;
        alu_we_i = 1; lsu_we_i = 1;
        @(posedge clk); #1;
        check("x0_pend", pend_o, 32'h0010_0000);
        check("x0_we", {30'd0, we_a_o, we_b_o}, 0);

        // in-flight ALU write seen by issue checks
        @(negedge clk); idle();
        alu_we_i = 1; alu_waddr_i = 12; alu_wdata_i = 32'h1234;
        @(negedge clk); idle(); chk_b_i = 12;
`ifdef RF_WB_FWD_EN
        #1 check("fwd12_haz", {31'd0, hazard_o}, 0);
        check("fwd12_sel_b", {31'd0, fwd_sel_b_o}, 1);
        check("fwd12_dat_b", fwd_data_b_o, 32'h1234);
        check("fwd12_sel_a", {31'd0, fwd_sel_a_o}, 0);
        check("fwd12_dat_a", fwd_data_a_o, 0);
`else
        #1 check("fly12_haz", {31'd0, hazard_o}, 1);
`endif

        // async reset mid-cycle, during a stalled MDU offer
        @(negedge clk); idle();
        alu_we_i = 1; alu_waddr_i = 5; alu_wdata_i = 32'h55;
        pend_set_i = 1; pend_rd_i = 21;
        @(posedge clk); #1 check("pre_rst_we_a", {31'd0, we_a_o}, 1);
        pend_set_i = 0; chk_a_i = 21;
        lsu_we_i = 1; lsu_waddr_i = 2; mdu_valid_i = 1; mdu_waddr_i = 3;
        #1 rst_n = 0;
        #1;
        check("arst_we_a", {31'd0, we_a_o}, 0);
        check("arst_wa_a", {27'd0, waddr_a_o}, 0);
        check("arst_wd_a", wdata_a_o, 0);
        check("arst_we_b", {31'd0, we_b_o}, 0);
        check("arst_pend", pend_o, 0);
        check("arst_haz", {31'd0, hazard_o}, 0);
        check("arst_rdy0", {31'd0, mdu_ready_o}, 0);
        lsu_we_i = 0;
        #1 check("arst_rdy1", {31'd0, mdu_ready_o}, 1);
        @(negedge clk); idle(); rst_n = 1;
        @(negedge clk);

        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL sb_drain: got %0d left expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    function automatic vec_t mdu_x0();
        return mk("mdu_x0", 0,0,0, 0,0,0, 1,0,32'h3, 1, 0,0,0, 0,0,0);
    endfunction

endmodule
